// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: resolves load-use, branch/jump redirect and
// data-memory wait hazards, with saturating perf counters and a sticky timeout flag.
module hazard_ctrl #(
  parameter int CNT_W    = 16,
  parameter int WAIT_MAX = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic [4:0]       ex_aw,
  input  logic             ex_regwrite,
  input  logic             ex_memtoreg,
  input  logic             ex_pcsrc,
  input  logic             ex_jump,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_write,
  output logic             exmem_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             timeout_err,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1
  } state_e;

  localparam logic [7:0] WAIT_LIMIT = 8'(WAIT_MAX);

  state_e           state_q;
  logic [7:0]       wait_cnt_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;
  logic             timeout_q;

  logic load_use;
  logic redirect;
  logic mem_stall;

  assign load_use  = ex_memtoreg & ex_regwrite & (ex_aw != 5'd0) &
                     ((ex_aw == id_rs) | (id_uses_rt & (ex_aw == id_rt)));
  assign redirect  = ex_pcsrc | ex_jump;
  assign mem_stall = mem_req & ~mem_ready;

  // NOTE: every output gets a default before the case so always_comb never infers a latch.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_write  = 1'b1;
    exmem_write = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    if (!rst_n) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          if (mem_stall) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            exmem_write = 1'b0;
          end else if (redirect) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (load_use) begin
            // Hold PC and IF/ID, insert one bubble into ID/EX.
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
          end
        end
        default: begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_write  = 1'b0;
          exmem_write = 1'b0;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      wait_cnt_q  <= 8'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      if (!pc_write && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
      case (state_q)
        RUN: begin
          if (mem_stall) begin
            state_q    <= MEM_WAIT;
            wait_cnt_q <= 8'd1;
          end else if (redirect && (flush_cnt_q != '1)) begin
            flush_cnt_q <= flush_cnt_q + 1'b1;
          end
        end
        default: begin
          if (mem_ready) begin
            state_q    <= RUN;
            wait_cnt_q <= 8'd0;
          end else if (wait_cnt_q == WAIT_LIMIT) begin
            // Abandon the access so a dead memory cannot hang the core.
            timeout_q  <= 1'b1;
            state_q    <= RUN;
            wait_cnt_q <= 8'd0;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end
      endcase
    end
  end

  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;
  assign timeout_err = timeout_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: per-cycle comparison against a behavioural
// model plus hand-computed checkpoints along a directed scenario.
module tb_hazard_ctrl;
  localparam int CNT_W    = 16;
  localparam int WAIT_MAX = 15;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, ex_aw = '0;
  logic id_uses_rt = 0, ex_regwrite = 0, ex_memtoreg = 0, ex_pcsrc = 0, ex_jump = 0;
  logic mem_req = 0, mem_ready = 0;
  logic pc_write, ifid_write, idex_write, exmem_write, ifid_flush, idex_flush;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic timeout_err;
  logic [1:0] state_o;

  int checks = 0;
  int errors = 0;

  hazard_ctrl #(.CNT_W(CNT_W), .WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_aw(ex_aw), .ex_regwrite(ex_regwrite), .ex_memtoreg(ex_memtoreg),
    .ex_pcsrc(ex_pcsrc), .ex_jump(ex_jump),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write(pc_write), .ifid_write(ifid_write), .idex_write(idex_write),
    .exmem_write(exmem_write), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
    .timeout_err(timeout_err), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: whether a memory access is stalling and how many stall cycles it has used.
  bit m_wait = 0;
  int m_len = 0;
  int m_stalls = 0;
  int m_flushes = 0;
  bit m_to = 0;

  initial begin
    forever begin
      logic [5:0] e_ctrl;
      bit ms, rd, lu;
      @(negedge clk);
      #3;
      if (!rst_n) begin
        m_wait = 0; m_len = 0; m_stalls = 0; m_flushes = 0; m_to = 0;
      end
      ms = mem_req && !mem_ready;
      rd = ex_pcsrc || ex_jump;
      lu = ex_memtoreg && ex_regwrite && (ex_aw != 0) &&
           ((ex_aw == id_rs) || (id_uses_rt && (ex_aw == id_rt)));
      // Order: pc, ifid, idex, exmem write enables, then ifid/idex flush.
      if (!rst_n)      e_ctrl = 6'b0000_11;
      else if (m_wait) e_ctrl = 6'b0000_00;
      else if (ms)     e_ctrl = 6'b0000_00;
      else if (rd)     e_ctrl = 6'b1111_11;
      else if (lu)     e_ctrl = 6'b0011_01;
      else             e_ctrl = 6'b1111_00;
      check("ctrl", {26'd0, pc_write, ifid_write, idex_write, exmem_write, ifid_flush, idex_flush},
            {26'd0, e_ctrl});
      check("state_timeout", {29'd0, state_o, timeout_err}, {29'd0, (m_wait ? 2'd1 : 2'd0), m_to});
      check("stall_cnt", {16'd0, stall_cnt}, m_stalls);
      check("flush_cnt", {16'd0, flush_cnt}, m_flushes);
      if (rst_n) begin
        if (!e_ctrl[5]) m_stalls = (m_stalls < CNT_MAX) ? m_stalls + 1 : CNT_MAX;
        if (!m_wait) begin
          if (ms) begin
            m_wait = 1; m_len = 1;
          end else if (rd) begin
            m_flushes = (m_flushes < CNT_MAX) ? m_flushes + 1 : CNT_MAX;
          end
        end else if (mem_ready) begin
          m_wait = 0; m_len = 0;
        end else if (m_len + 1 > WAIT_MAX) begin
          m_to = 1; m_wait = 0; m_len = 0;
        end else begin
          m_len = m_len + 1;
        end
      end
    end
  end

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                       input logic [4:0] aw, input logic rw, input logic m2r,
                       input logic pcs, input logic jmp, input logic req, input logic rdy);
    @(negedge clk);
    #1;
    id_rs = rs; id_rt = rt; id_uses_rt = urt; ex_aw = aw;
    ex_regwrite = rw; ex_memtoreg = m2r; ex_pcsrc = pcs; ex_jump = jmp;
    mem_req = req; mem_ready = rdy;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;

    // Quiet pipeline.
    idle(10); #3;
    check("t1_stall", {16'd0, stall_cnt}, 32'd0);
    check("t1_flush", {16'd0, flush_cnt}, 32'd0);
    check("t1_ctrl", {26'd0, pc_write, ifid_write, idex_write, exmem_write, ifid_flush, idex_flush},
          32'b111100);

    // Load-use on rs, then a load to $0, then rt with and without id_uses_rt.
    drive(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1); #3;
    check("t2_stall_rs", {16'd0, stall_cnt}, 32'd1);
    drive(5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1); #3;
    check("t2_stall_r0", {16'd0, stall_cnt}, 32'd1);
    drive(5'd3, 5'd7, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(5'd3, 5'd7, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1); #3;
    check("t2_stall_rt", {16'd0, stall_cnt}, 32'd2);

    // Redirect beats load-use; then a lone jump.
    drive(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1); #3;
    check("t3_flush", {16'd0, flush_cnt}, 32'd1);
    check("t3_stall", {16'd0, stall_cnt}, 32'd2);
    drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(1); #3;
    check("t3_jump", {16'd0, flush_cnt}, 32'd2);

    // Memory wait of 3 cycles then ready; jump during the stall is not counted.
    drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); #3;
    check("t4_state_wait", {30'd0, state_o}, 32'd1);
    drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(1); #3;
    check("t4_stall", {16'd0, stall_cnt}, 32'd6);
    check("t4_flush", {16'd0, flush_cnt}, 32'd2);
    check("t4_state_run", {30'd0, state_o}, 32'd0);

    // Memory never answers: timeout after 16 stall cycles.
    repeat (16) drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1); #3;
    check("t5_timeout", {31'd0, timeout_err}, 32'd1);
    check("t5_state", {30'd0, state_o}, 32'd0);
    check("t5_stall", {16'd0, stall_cnt}, 32'd22);
    idle(3); #3;
    check("t5_sticky", {31'd0, timeout_err}, 32'd1);

    // Asynchronous reset in the middle of a memory wait.
    repeat (3) drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #2;
    check("t6_state", {30'd0, state_o}, 32'd0);
    check("t6_ctrl", {26'd0, pc_write, ifid_write, idex_write, exmem_write, ifid_flush, idex_flush},
          32'b000011);
    check("t6_stall", {16'd0, stall_cnt}, 32'd0);
    check("t6_timeout", {31'd0, timeout_err}, 32'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    mem_req = 1'b0;
    idle(2); #3;
    check("t6_release", {26'd0, pc_write, ifid_write, idex_write, exmem_write, ifid_flush, idex_flush},
          32'b111100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
